// File: rtl/vote_pkg.sv
// -----------------------------------------------------------------------------
// vote_pkg
// Shared types and helpers for the vote input conditioning front end.
//   NUM_CANDIDATES : number of candidate buttons
//   cand_idx_t     : candidate index 0..3
//   cand_vec_t     : one bit per candidate (bit0 = button1)
//   cond_state_t   : conditioner FSM states
//   onehot_to_idx  : encode a one-hot candidate vector to its index
//   is_onehot      : true when exactly one candidate bit is set
// -----------------------------------------------------------------------------
package vote_pkg;

   localparam int NUM_CANDIDATES = 4;

   typedef logic [1:0] cand_idx_t;
   typedef logic [3:0] cand_vec_t;

   typedef enum logic [2:0] {
      IDLE         = 3'd0,
      DEBOUNCE     = 3'd1,
      ISSUE        = 3'd2,
      REJECT       = 3'd3,
      WAIT_RELEASE = 3'd4
   } cond_state_t;

   // Non-one-hot inputs map to index 0; callers only use this on one-hot data.
   function automatic cand_idx_t onehot_to_idx(input cand_vec_t vec);
      cand_idx_t idx;
      case (vec)
         4'b0001: idx = 2'd0;
         4'b0010: idx = 2'd1;
         4'b0100: idx = 2'd2;
         4'b1000: idx = 2'd3;
         default: idx = 2'd0;
      endcase
      return idx;
   endfunction

   // Clearing the lowest set bit leaves zero only for a single-bit vector.
   function automatic logic is_onehot(input cand_vec_t vec);
      return (vec != 4'b0000) && ((vec & (vec - 4'b0001)) == 4'b0000);
   endfunction

endpackage

// File: rtl/vote_input_conditioner_sync_2ff.sv
// -----------------------------------------------------------------------------
// sync_2ff
// Two-flop synchroniser for a vector of independent asynchronous inputs.
//   clk_i   : destination clock
//   rst_i   : asynchronous active-high reset, clears both stages
//   async_i : raw asynchronous inputs
//   sync_o  : inputs re-timed into the clk_i domain (two-cycle delay)
// Each bit is synchronised on its own; no coherency between bits is implied.
// -----------------------------------------------------------------------------
module sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] async_i,
   output logic [WIDTH-1:0] sync_o
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   // Metastability stage followed by the stable output stage.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         meta_q <= {WIDTH{1'b0}};
         sync_q <= {WIDTH{1'b0}};
      end else begin
         meta_q <= async_i;
         sync_q <= meta_q;
      end
   end

   assign sync_o = sync_q;

endmodule

// File: rtl/vote_input_conditioner.sv
// -----------------------------------------------------------------------------
// vote_input_conditioner
// Synchronises and debounces the four candidate buttons and the mode switch,
// and turns each accepted press into exactly one single-cycle vote strobe.
//   clock           : system clock, rising edge
//   reset           : asynchronous active-high reset
//   mode            : 0 = voting, 1 = result view (asynchronous)
//   button1..4      : raw candidate buttons, active high (asynchronous)
//   vote_valid      : one-cycle strobe per accepted vote
//   vote_sel        : candidate index with vote_valid, else 0
//   vote_onehot     : one-hot candidate with vote_valid, else 0
//   multi_press_err : one-cycle pulse when a debounced press had >1 button
//   busy            : high whenever the FSM is not in IDLE
// All outputs are flops loaded from the next-state decode, so they change on
// the same edge the FSM enters ISSUE/REJECT and have no input-to-output path.
// -----------------------------------------------------------------------------
module vote_input_conditioner
   import vote_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 10
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       mode,
   input  logic       button1,
   input  logic       button2,
   input  logic       button3,
   input  logic       button4,
   output logic       vote_valid,
   output logic [1:0] vote_sel,
   output logic [3:0] vote_onehot,
   output logic       multi_press_err,
   output logic       busy
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [4:0]  raw_s;
   logic [4:0]  sync_s;
   cand_vec_t   btn_s;
   logic        mode_s;

   cond_state_t      state_q, state_d;
   cand_vec_t        cap_q, cap_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic        vote_valid_q, vote_valid_d;
   cand_idx_t   vote_sel_q, vote_sel_d;
   cand_vec_t   vote_onehot_q, vote_onehot_d;
   logic        multi_press_err_q, multi_press_err_d;
   logic        busy_q, busy_d;

   assign raw_s = {mode, button4, button3, button2, button1};

   sync_2ff #(
      .WIDTH (5)
   ) u_sync (
      .clk_i   (clock),
      .rst_i   (reset),
      .async_i (raw_s),
      .sync_o  (sync_s)
   );

   assign btn_s  = sync_s[3:0];
   assign mode_s = sync_s[4];

   // Next-state logic for the press / debounce / release sequencer.
   always_comb begin
      state_d = state_q;
      cap_d   = cap_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (btn_s != 4'b0000) begin
               cnt_d = CNT_ZERO;
               if (!mode_s) begin
                  cap_d   = btn_s;
                  state_d = DEBOUNCE;
               end else begin
                  // Presses in result view are swallowed until released.
                  state_d = WAIT_RELEASE;
               end
            end else begin
               state_d = IDLE;
            end
         end
         DEBOUNCE: begin
            if (btn_s != cap_q) begin
               // Any change restarts qualification from IDLE.
               state_d = IDLE;
               cnt_d   = CNT_ZERO;
            end else if (mode_s) begin
               state_d = WAIT_RELEASE;
               cnt_d   = CNT_ZERO;
            end else if (cnt_q == CNT_LAST) begin
               state_d = is_onehot(cap_q) ? ISSUE : REJECT;
               cnt_d   = CNT_ZERO;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ISSUE, REJECT: begin
            state_d = WAIT_RELEASE;
            cnt_d   = CNT_ZERO;
         end
         WAIT_RELEASE: begin
            if (btn_s != 4'b0000) begin
               // A held or re-pressed button restarts the release countdown.
               cnt_d = CNT_ZERO;
            end else if (cnt_q == CNT_LAST) begin
               state_d = IDLE;
               cnt_d   = CNT_ZERO;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            state_d = IDLE;
            cap_d   = 4'b0000;
            cnt_d   = CNT_ZERO;
         end
      endcase
   end

   // Output decode from the state being entered, so the flops line up with it.
   always_comb begin
      vote_valid_d      = 1'b0;
      vote_sel_d        = 2'd0;
      vote_onehot_d     = 4'b0000;
      multi_press_err_d = 1'b0;
      busy_d            = (state_d != IDLE);
      if (state_d == ISSUE) begin
         vote_valid_d  = 1'b1;
         vote_sel_d    = onehot_to_idx(cap_d);
         vote_onehot_d = cap_d;
      end else if (state_d == REJECT) begin
         multi_press_err_d = 1'b1;
      end else begin
         vote_valid_d      = 1'b0;
         multi_press_err_d = 1'b0;
      end
   end

   // FSM state, captured pattern and debounce counter.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cap_q   <= 4'b0000;
         cnt_q   <= CNT_ZERO;
      end else begin
         state_q <= state_d;
         cap_q   <= cap_d;
         cnt_q   <= cnt_d;
      end
   end

   // Registered outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         vote_valid_q      <= 1'b0;
         vote_sel_q        <= 2'd0;
         vote_onehot_q     <= 4'b0000;
         multi_press_err_q <= 1'b0;
         busy_q            <= 1'b0;
      end else begin
         vote_valid_q      <= vote_valid_d;
         vote_sel_q        <= vote_sel_d;
         vote_onehot_q     <= vote_onehot_d;
         multi_press_err_q <= multi_press_err_d;
         busy_q            <= busy_d;
      end
   end

   assign vote_valid      = vote_valid_q;
   assign vote_sel        = vote_sel_q;
   assign vote_onehot     = vote_onehot_q;
   assign multi_press_err = multi_press_err_q;
   assign busy            = busy_q;

endmodule

// File: tb/tb_vote_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_vote_input_conditioner
// Directed stimulus with a scoreboard: every press that should produce a strobe
// pushes the expected strobe (kind, index, one-hot, arrival cycle) into a queue;
// a monitor pops and compares whenever the DUT raises vote_valid or
// multi_press_err. Any strobe with nothing queued is an error, as is anything
// left in the queue at the end.
// -----------------------------------------------------------------------------
module tb_vote_input_conditioner;

   logic       clock;
   logic       reset;
   logic       mode;
   logic       button1, button2, button3, button4;
   logic       vote_valid;
   logic [1:0] vote_sel;
   logic [3:0] vote_onehot;
   logic       multi_press_err;
   logic       busy;

   typedef struct {
      logic       is_err;
      logic [1:0] sel;
      logic [3:0] oh;
      int         cyc;
   } exp_t;

   exp_t exp_q[$];
   int   cyc;
   int   n_checks;
   int   n_fail;

   vote_input_conditioner #(
      .DEBOUNCE_CYCLES (10)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .mode            (mode),
      .button1         (button1),
      .button2         (button2),
      .button3         (button3),
      .button4         (button4),
      .vote_valid      (vote_valid),
      .vote_sel        (vote_sel),
      .vote_onehot     (vote_onehot),
      .multi_press_err (multi_press_err),
      .busy            (busy)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Free-running cycle count, used to timestamp expected strobes.
   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks = n_checks + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Press applied at a negedge is sampled by stage 1 at the next edge (k);
   // the strobe is seen at the negedge following edge k+12.
   task automatic expect_strobe(input logic is_err, input logic [1:0] sel, input logic [3:0] oh);
      exp_t e;
      e.is_err = is_err;
      e.sel    = sel;
      e.oh     = oh;
      e.cyc    = cyc + 13;
      exp_q.push_back(e);
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic set_buttons(input logic [3:0] b);
      {button4, button3, button2, button1} = b;
   endtask

   task automatic check_outputs_zero(input string name);
      check(name, {26'd0, vote_valid, vote_sel, vote_onehot, multi_press_err, busy}, 32'd0);
   endtask

   // Monitor: compare every strobe against the scoreboard; outside strobes
   // vote_sel and vote_onehot must be zero.
   always @(negedge clock) begin
      exp_t e;
      if (!reset) begin
         if (vote_valid || multi_press_err) begin
            if (exp_q.size() == 0) begin
               check("unexpected_strobe", {30'd0, vote_valid, multi_press_err}, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("strobe_kind", {30'd0, vote_valid, multi_press_err},
                     e.is_err ? 32'd1 : 32'd2);
               check("strobe_cycle", cyc, e.cyc);
               check("vote_sel", {30'd0, vote_sel}, e.is_err ? 32'd0 : {30'd0, e.sel});
               check("vote_onehot", {28'd0, vote_onehot}, e.is_err ? 32'd0 : {28'd0, e.oh});
            end
         end else begin
            check("idle_sel_onehot", {26'd0, vote_sel, vote_onehot}, 32'd0);
         end
      end
   end

   initial begin
      cyc      = 0;
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b1;
      mode     = 1'b0;
      set_buttons(4'b0000);

      // Reset held 200 ns: everything stays zero.
      for (int i = 0; i < 20; i++) begin
         @(negedge clock);
         check_outputs_zero("reset_outputs");
      end
      reset = 1'b0;
      wait_cycles(3);
      check_outputs_zero("post_reset_idle");

      // Single button1 press held 200 ns: one vote, index 0.
      set_buttons(4'b0001);
      expect_strobe(1'b0, 2'd0, 4'b0001);
      wait_cycles(5);
      check("busy_debounce", {31'd0, busy}, 32'd1);
      wait_cycles(15);
      set_buttons(4'b0000);
      wait_cycles(20);
      check("busy_after_b1", {31'd0, busy}, 32'd0);

      // button2 glitch for 5 cycles: rejected as bounce.
      set_buttons(4'b0010);
      wait_cycles(5);
      set_buttons(4'b0000);
      wait_cycles(12);
      check("busy_after_glitch", {31'd0, busy}, 32'd0);

      // button2 + button3 together: one multi-press error.
      set_buttons(4'b0110);
      expect_strobe(1'b1, 2'd0, 4'b0000);
      wait_cycles(20);
      set_buttons(4'b0000);
      wait_cycles(20);
      check("busy_after_multi", {31'd0, busy}, 32'd0);

      // Result view: button2 press is swallowed.
      mode = 1'b1;
      wait_cycles(4);
      set_buttons(4'b0010);
      wait_cycles(20);
      check("busy_mode_hold", {31'd0, busy}, 32'd1);
      set_buttons(4'b0000);
      wait_cycles(20);
      mode = 1'b0;
      wait_cycles(5);
      check("busy_after_mode", {31'd0, busy}, 32'd0);

      // Back in voting mode: button2 votes index 1.
      set_buttons(4'b0010);
      expect_strobe(1'b0, 2'd1, 4'b0010);
      wait_cycles(20);
      set_buttons(4'b0000);
      wait_cycles(20);

      // button3: vote, short release (no re-vote), long release, re-vote.
      set_buttons(4'b0100);
      expect_strobe(1'b0, 2'd2, 4'b0100);
      wait_cycles(20);
      set_buttons(4'b0000);
      wait_cycles(4);
      set_buttons(4'b0100);
      wait_cycles(20);
      set_buttons(4'b0000);
      wait_cycles(12);
      set_buttons(4'b0100);
      expect_strobe(1'b0, 2'd2, 4'b0100);
      wait_cycles(20);
      set_buttons(4'b0000);
      wait_cycles(20);
      check("busy_after_b3", {31'd0, busy}, 32'd0);

      // button4, reset mid-debounce, held through reset: vote after reset.
      set_buttons(4'b1000);
      wait_cycles(9);
      check("busy_b4_debounce", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      #1;
      check_outputs_zero("async_reset_clear");
      for (int i = 0; i < 3; i++) begin
         @(negedge clock);
         check_outputs_zero("reset_mid_debounce");
      end
      reset = 1'b0;
      expect_strobe(1'b0, 2'd3, 4'b1000);
      wait_cycles(20);
      set_buttons(4'b0000);
      wait_cycles(25);
      check("busy_final", {31'd0, busy}, 32'd0);

      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
